// File: rtl/ps2_pkg.sv
// Shared types and shift-register control codes for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [2:0] SR_CLEAR  = 3'b000;
    localparam logic [2:0] SR_LOAD   = 3'b001;
    localparam logic [2:0] SR_SHR_IN = 3'b101;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW+1)'(1);
        if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: drives an external 8-bit shift register LSB-first,
// checks start/parity/stop and queues good bytes for a valid/ready consumer.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] sr_ctrl,
    output logic       sr_instream,
    output logic [7:0] sr_data_in,
    input  logic [7:0] sr_q,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       frame_err,
    output logic       timeout_err
);
    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic          clk_m_q, clk_s_q, clk_p_q, data_m_q, data_s_q;
    logic          fall;
    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout_err_q, timeout_err_d;
    logic          overflow_q, overflow_d;
    logic [2:0]    ctrl;
    logic          instream;
    logic          push, pop;
    logic          fifo_empty, fifo_full;
    logic [7:0]    fifo_head;

    // Idle-high reset on the synchronisers keeps reset release from looking like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_m_q  <= 1'b1;
            clk_s_q  <= 1'b1;
            clk_p_q  <= 1'b1;
            data_m_q <= 1'b1;
            data_s_q <= 1'b1;
        end else begin
            clk_m_q  <= ps2_clk;
            clk_s_q  <= clk_m_q;
            clk_p_q  <= clk_s_q;
            data_m_q <= ps2_data;
            data_s_q <= data_m_q;
        end
    end

    assign fall = clk_p_q & ~clk_s_q;

    always_comb begin
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        par_d         = par_q;
        tmo_d         = tmo_q;
        ctrl          = SR_LOAD;
        instream      = 1'b0;
        push          = 1'b0;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_s_q) begin
                        ctrl     = SR_CLEAR;
                        bitcnt_d = 3'd0;
                        state_d  = DATA;
                    end
                end
                DATA: begin
                    ctrl     = SR_SHR_IN;
                    instream = data_s_q;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_s_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_s_q && ((^sr_q) ^ par_q)) push = 1'b1;
                    else                               frame_err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d       = IDLE;
                tmo_d         = '0;
                timeout_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    assign pop        = out_valid & out_ready;
    assign overflow_d = (push && fifo_full && !pop) ? 1'b1 :
                        ovf_clr                     ? 1'b0 : overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bitcnt_q      <= 3'd0;
            par_q         <= 1'b0;
            tmo_q         <= '0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            par_q         <= par_d;
            tmo_q         <= tmo_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            overflow_q    <= overflow_d;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (sr_q),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // The shift register is cleared for as long as reset is held.
    assign sr_ctrl     = rst_n ? ctrl : SR_CLEAR;
    assign sr_instream = rst_n & instream;
    assign sr_data_in  = sr_q;
    assign out_valid   = ~fifo_empty;
    assign out_data    = fifo_empty ? 8'h00 : fifo_head;
    assign overflow    = overflow_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: models the external shift register, drives PS/2 frames,
// and scoreboards the output bytes against a queue of expected values.
module tb_ps2_rx_ctrl;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n, ps2_clk, ps2_data;
    logic [2:0] sr_ctrl;
    logic       sr_instream;
    logic [7:0] sr_data_in, sr_q;
    logic       out_valid, out_ready, overflow, ovf_clr, frame_err, timeout_err;
    logic [7:0] out_data;

    int total = 0;
    int bad   = 0;
    int ferr_cnt = 0;
    int tmo_cnt  = 0;
    logic [7:0] exp_q[$];
    logic [2:0] ctrl_log[$];
    logic [7:0] mon_exp;

    ps2_rx_ctrl #(.DEPTH(4), .TIMEOUT(50)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .sr_ctrl     (sr_ctrl),
        .sr_instream (sr_instream),
        .sr_data_in  (sr_data_in),
        .sr_q        (sr_q),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .frame_err   (frame_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // External N=8 shift register.
    always @(posedge clk) begin
        case (sr_ctrl)
            3'b000:  sr_q <= 8'h00;
            3'b001:  sr_q <= sr_data_in;
            3'b101:  sr_q <= {sr_instream, sr_q[7:1]};
            default: sr_q <= sr_q;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (sr_ctrl != 3'b001) ctrl_log.push_back(sr_ctrl);
            if (frame_err)   ferr_cnt++;
            if (timeout_err) tmo_cnt++;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected got=%02h want=none", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (out_data !== mon_exp) begin
                        bad++;
                        $display("FAIL pop_data got=%02h want=%02h", out_data, mon_exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    task automatic send_bit(input logic v, input bit pop_on_fall);
        @(negedge clk);
        ps2_data = v;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop_on_fall) begin
            @(posedge clk);
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input bit pop_on_stop);
        logic [10:0] f;
        f = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i], (i == 10) && pop_on_stop);
        repeat (4) @(negedge clk);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
        chk("drain_valid", out_valid, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sr_ctrl", sr_ctrl, 3'b000);
        chk("rst_instream", sr_instream, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_terr", timeout_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_hold", sr_ctrl, 3'b001);

        // Good frame 0x1C
        ctrl_log.delete();
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        chk("good_ctrl_len", ctrl_log.size(), 9);
        for (int i = 0; i < 9 && i < ctrl_log.size(); i++)
            chk("good_ctrl_seq", ctrl_log[i], (i == 0) ? 3'b000 : 3'b101);
        chk("good_sr_q", sr_q, 8'h1C);
        chk("good_valid", out_valid, 1);
        chk("good_head", out_data, 8'h1C);
        chk("good_ferr", ferr_cnt, 0);
        drain();

        // Bad parity, then bad stop
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        chk("badpar_ferr", ferr_cnt, 1);
        chk("badpar_valid", out_valid, 0);
        send_frame(8'hF0, 1'b1, 1'b0, 0);
        chk("badstop_ferr", ferr_cnt, 2);
        chk("badstop_valid", out_valid, 0);

        // Timeout after 4 data bits
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1 n++;
            if (n == 10) ps2_clk = 1'b1;
            if (timeout_err) break;
        end
        chk("tmo_latency", n, 50);
        repeat (4) @(negedge clk);
        chk("tmo_count", tmo_cnt, 1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1, 0);
        chk("after_tmo_valid", out_valid, 1);
        drain();

        // Overflow with DEPTH=4
        exp_q.push_back(8'h01); send_frame(8'h01, 1'b0, 1'b1, 0);
        exp_q.push_back(8'h02); send_frame(8'h02, 1'b0, 1'b1, 0);
        exp_q.push_back(8'h03); send_frame(8'h03, 1'b1, 1'b1, 0);
        exp_q.push_back(8'h04); send_frame(8'h04, 1'b0, 1'b1, 0);
        chk("pre_ovf", overflow, 0);
        send_frame(8'h05, 1'b1, 1'b1, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_head", out_data, 8'h01);
        @(negedge clk) ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);
        drain();

        // Full FIFO: pop in the stop-bit cycle lets the push in
        exp_q.push_back(8'h11); send_frame(8'h11, 1'b1, 1'b1, 0);
        exp_q.push_back(8'h12); send_frame(8'h12, 1'b1, 1'b1, 0);
        exp_q.push_back(8'h13); send_frame(8'h13, 1'b0, 1'b1, 0);
        exp_q.push_back(8'h14); send_frame(8'h14, 1'b1, 1'b1, 0);
        exp_q.push_back(8'h15); send_frame(8'h15, 1'b0, 1'b1, 1);
        chk("full_pp_ovf", overflow, 0);
        chk("full_pp_head", out_data, 8'h12);
        drain();
        chk("ferr_total", ferr_cnt, 2);

        // Reset during bit 3
        exp_q.push_back(8'h33); send_frame(8'h33, 1'b1, 1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        @(negedge clk);
        ps2_data = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_ctrl", sr_ctrl, 3'b000);
        chk("mid_rst_instream", sr_instream, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 8'h00);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_errs", {frame_err, timeout_err}, 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_hold_ctrl", sr_ctrl, 3'b000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        chk("post_rst_head", out_data, 8'hA5);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
